// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: default geometry of the
// data RAM, the read-owner tag carried across the one-cycle RAM read
// latency, and a saturating increment used by the optional performance
// counters (enabled with the DMEM_ARB_PERF_EN macro in dmem_arbiter).
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_DEPTH  = 4096;
    localparam int PERF_W      = 16;

    // Which port issued the read whose data comes back from the RAM this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
        if (value == {PERF_W{1'b1}}) begin
            return value;
        end
        return value + PERF_W'(1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
// Two-request round-robin arbiter. Grants at most one requester per cycle,
// combinationally from the current requests and the registered pointer of
// the most recent winner. On a conflict the port that did not win last
// time is granted, so each port waits at most one cycle.
//
// Ports:
//   clock       system clock
//   CPU_RESETN  asynchronous active-low reset (pointer resets to port 1 so
//               port 0 wins the first conflict)
//   req[1:0]    request per port
//   gnt[1:0]    one-hot (or zero) grant
module rr_arb2 (
    input  logic       clock,
    input  logic       CPU_RESETN,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;
    logic last_next;

    // Pointer register: remembers which port was granted most recently.
    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            last <= 1'b1;
        end else begin
            last <= last_next;
        end
    end

    // Pointer moves to whichever port was granted; it holds on idle cycles.
    always_comb begin
        last_next = last;
        if (gnt[0]) begin
            last_next = 1'b0;
        end else if (gnt[1]) begin
            last_next = 1'b1;
        end
    end

    // Grant decode: a lone requester always wins; on a conflict the port
    // that is not the last winner goes first.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port, synchronous-read data RAM between the processor
// data port (p0) and a secondary master (p1, debug/DMA loader). One access
// per cycle is granted round-robin; read data arriving one cycle later is
// routed back only to the port that issued the read.
//
// Optional feature: define DMEM_ARB_PERF_EN to add the saturating 16-bit
// counters perf_conflicts (cycles with both requests high) and
// perf_p0_stalls (cycles with p0_stall high).
//
// Ports:
//   clock, CPU_RESETN             clock, asynchronous active-low reset
//   pX_req/we/addr/wdata          request from port X, held until granted
//   pX_gnt                        access accepted this cycle
//   p0_stall                      p0 requesting but not granted
//   pX_rvalid/rdata               read return, one cycle after the grant
//   ram_wen/addr/din, ram_dout    single-port RAM interface
//   oor_err                       sticky flag: a granted access hit addr >= DEPTH
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clock,
    input  logic              CPU_RESETN,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,

    output logic              oor_err
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_conflicts,
    output logic [PERF_W-1:0] perf_p0_stalls
`endif
);

    logic [1:0]        req_live;
    logic [1:0]        gnt;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;
    owner_t            rd_own;
    owner_t            rd_own_next;
    logic              rd_oor;

    // Requests are masked while reset is held so that nothing is granted
    // and no RAM write can slip through before reset is released.
    assign req_live = {p1_req, p0_req} & {2{CPU_RESETN}};

    rr_arb2 u_arb (
        .clock      (clock),
        .CPU_RESETN (CPU_RESETN),
        .req        (req_live),
        .gnt        (gnt)
    );

    assign p0_gnt   = gnt[0];
    assign p1_gnt   = gnt[1];
    assign p0_stall = req_live[0] & ~gnt[0];
    assign any_gnt  = |gnt;

    // RAM-side mux: p1 only when p1 is granted, otherwise p0 values are
    // presented (with the write enable dropped when nobody is granted).
    always_comb begin
        sel_we    = p0_we;
        sel_addr  = p0_addr;
        sel_wdata = p0_wdata;
        if (gnt[1]) begin
            sel_we    = p1_we;
            sel_addr  = p1_addr;
            sel_wdata = p1_wdata;
        end
    end

    // Range check is done in 32 bits because DEPTH may equal 2**ADDR_W.
    assign sel_oor  = 32'(sel_addr) >= 32'(DEPTH);

    assign ram_wen  = any_gnt & sel_we & ~sel_oor;
    assign ram_addr = sel_addr;
    assign ram_din  = sel_wdata;

    // Tag for the read that the RAM will answer next cycle; re-evaluated
    // every cycle so back-to-back reads simply overwrite it.
    always_comb begin
        rd_own_next = OWN_NONE;
        if (any_gnt && !sel_we) begin
            rd_own_next = gnt[1] ? OWN_P1 : OWN_P0;
        end
    end

    // Read-owner pipeline plus the flag that turns an out-of-range read
    // into a zero return, and the sticky out-of-range error.
    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rd_own  <= OWN_NONE;
            rd_oor  <= 1'b0;
            oor_err <= 1'b0;
        end else begin
            rd_own <= rd_own_next;
            rd_oor <= sel_oor;
            if (any_gnt && sel_oor) begin
                oor_err <= 1'b1;
            end
        end
    end

    // Read return: only the owning port sees data; the other reads zero.
    always_comb begin
        p0_rvalid = (rd_own == OWN_P0);
        p1_rvalid = (rd_own == OWN_P1);
        p0_rdata  = '0;
        p1_rdata  = '0;
        if (p0_rvalid && !rd_oor) begin
            p0_rdata = ram_dout;
        end
        if (p1_rvalid && !rd_oor) begin
            p1_rdata = ram_dout;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Saturating event counters for contention and processor stalls.
    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            perf_conflicts <= '0;
            perf_p0_stalls <= '0;
        end else begin
            if (&req_live) begin
                perf_conflicts <= sat_inc(perf_conflicts);
            end
            if (p0_stall) begin
                perf_p0_stalls <= sat_inc(perf_p0_stalls);
            end
        end
    end
`endif

endmodule
